// File: rtl/clkdiv_bank.sv
// Bank of N independent programmable clock dividers sharing one divisor write
// port and a common phase-realignment pulse. All outputs except wr_ready are registered.
module clkdiv_bank #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int DEF_DIV = 2,
    localparam int SW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  en_i,
    input  logic          sync_i,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [SW-1:0] wr_sel,
    input  logic [W-1:0]  wr_div,
    output logic          err_o,
    output logic [N-1:0]  clk_o,
    output logic [N-1:0]  stb_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } state_t;

    logic [N-1:0] sel_hit_s;
    logic [N-1:0] pend_s;
    logic         sel_ok_s;
    logic         sel_pend_s;
    logic         wr_acc_s;
    logic         div_ok_s;
    logic         wr_apply_s;
    logic         err_nxt_s;
    logic         err_r;

    // One-hot decode of the write target; an out-of-range select hits nothing
    always_comb begin
        sel_hit_s = '0;
        for (int i = 0; i < N; i++) begin
            if (wr_sel == SW'(i)) begin
                sel_hit_s[i] = 1'b1;
            end else begin
                sel_hit_s[i] = 1'b0;
            end
        end
    end

    // Write handshake and error classification
    always_comb begin
        sel_ok_s   = |sel_hit_s;
        sel_pend_s = |(sel_hit_s & pend_s);
        if (!reset_n) begin
            wr_ready = 1'b1;
        end else begin
            wr_ready = !sel_pend_s;
        end
        wr_acc_s   = reset_n && wr_valid && wr_ready;
        div_ok_s   = (wr_div >= W'(2));
        wr_apply_s = wr_acc_s && sel_ok_s && div_ok_s;
        err_nxt_s  = wr_acc_s && !(sel_ok_s && div_ok_s);
    end

    // Error pulse register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nxt_s;
        end
    end

    assign err_o = err_r;

    for (genvar g = 0; g < N; g++) begin : g_ch
        state_t       st_r;
        state_t       st_nxt_s;
        logic [W-1:0] m_r;
        logic [W-1:0] m_nxt_s;
        logic [W-1:0] p_r;
        logic [W-1:0] p_nxt_s;
        logic [W-1:0] pd_r;
        logic [W-1:0] pd_nxt_s;
        logic [W-1:0] high_s;
        logic         pf_r;
        logic         pf_nxt_s;
        logic         co_r;
        logic         co_nxt_s;
        logic         so_r;
        logic         so_nxt_s;
        logic         wrap_s;
        logic         hit_s;

        assign high_s = m_r - (m_r >> 1);
        assign wrap_s = (p_r == (m_r - W'(1)));
        assign hit_s  = wr_apply_s && sel_hit_s[g];

        // Channel next-state: the divisor only changes at a period boundary or sync
        always_comb begin
            st_nxt_s = st_r;
            m_nxt_s  = m_r;
            p_nxt_s  = p_r;
            pd_nxt_s = pd_r;
            pf_nxt_s = pf_r;
            co_nxt_s = 1'b0;
            so_nxt_s = 1'b0;
            case (st_r)
                ST_IDLE: begin
                    p_nxt_s = '0;
                    // A write that landed on the stopping edge is applied here
                    if (pf_r) begin
                        m_nxt_s  = pd_r;
                        pf_nxt_s = 1'b0;
                    end else begin
                        pf_nxt_s = 1'b0;
                    end
                    if (hit_s) begin
                        m_nxt_s = wr_div;
                    end else begin
                        pd_nxt_s = pd_r;
                    end
                    if (en_i[g]) begin
                        st_nxt_s = ST_RUN;
                        co_nxt_s = 1'b1;
                        so_nxt_s = 1'b1;
                        p_nxt_s  = W'(1);
                    end else begin
                        st_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN, ST_STOP: begin
                    if (sync_i) begin
                        if (pf_r) begin
                            m_nxt_s  = pd_r;
                            pf_nxt_s = 1'b0;
                        end else begin
                            pf_nxt_s = 1'b0;
                        end
                        co_nxt_s = 1'b1;
                        so_nxt_s = 1'b1;
                        p_nxt_s  = W'(1);
                        st_nxt_s = en_i[g] ? ST_RUN : ST_STOP;
                    end else begin
                        co_nxt_s = (p_r < high_s);
                        so_nxt_s = (p_r == '0);
                        if (wrap_s) begin
                            p_nxt_s = '0;
                            if (pf_r) begin
                                m_nxt_s  = pd_r;
                                pf_nxt_s = 1'b0;
                            end else begin
                                pf_nxt_s = 1'b0;
                            end
                            if (en_i[g]) begin
                                st_nxt_s = ST_RUN;
                            end else begin
                                st_nxt_s = ST_IDLE;
                                co_nxt_s = 1'b0;
                                so_nxt_s = 1'b0;
                            end
                        end else begin
                            p_nxt_s  = p_r + W'(1);
                            st_nxt_s = en_i[g] ? ST_RUN : ST_STOP;
                        end
                    end
                    // A write on a boundary edge waits for the next boundary
                    if (hit_s) begin
                        pf_nxt_s = 1'b1;
                        pd_nxt_s = wr_div;
                    end else begin
                        pd_nxt_s = pd_r;
                    end
                end
                default: begin
                    st_nxt_s = ST_IDLE;
                    p_nxt_s  = '0;
                    pf_nxt_s = 1'b0;
                end
            endcase
        end

        // Channel state and output registers
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                st_r <= ST_IDLE;
                m_r  <= W'(DEF_DIV);
                p_r  <= '0;
                pd_r <= W'(DEF_DIV);
                pf_r <= 1'b0;
                co_r <= 1'b0;
                so_r <= 1'b0;
            end else begin
                st_r <= st_nxt_s;
                m_r  <= m_nxt_s;
                p_r  <= p_nxt_s;
                pd_r <= pd_nxt_s;
                pf_r <= pf_nxt_s;
                co_r <= co_nxt_s;
                so_r <= so_nxt_s;
            end
        end

        assign pend_s[g] = pf_r;
        assign clk_o[g]  = co_r;
        assign stb_o[g]  = so_r;
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Scoreboard bench for clkdiv_bank: directed steps push hand-computed outputs,
// a negedge monitor pops and compares. N=5 so that wr_sel=5 is out of range.
module tb_clkdiv_bank;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  en_i = '0;
    logic          sync_i = 1'b0;
    logic          wr_valid = 1'b0;
    logic [SW-1:0] wr_sel = '0;
    logic [W-1:0]  wr_div = '0;
    logic          wr_ready;
    logic          err_o;
    logic [N-1:0]  clk_o;
    logic [N-1:0]  stb_o;

    typedef struct packed {
        logic [N-1:0] c;
        logic [N-1:0] s;
        logic         e;
    } exp_t;

    typedef struct packed {
        logic e;
        logic a;
    } rdy_t;

    exp_t sb_q[$];
    rdy_t rdy_q[$];
    exp_t mon_x;
    rdy_t mon_r;
    int   total = 0;
    int   bad = 0;

    clkdiv_bank #(.N(N), .W(W), .DEF_DIV(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (en_i),
        .sync_i   (sync_i),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_sel   (wr_sel),
        .wr_div   (wr_div),
        .err_o    (err_o),
        .clk_o    (clk_o),
        .stb_o    (stb_o)
    );

    always #5 clk = ~clk;

    // Monitor: pop expectations and compare on the falling edge
    always @(negedge clk) begin
        while (rdy_q.size() > 0) begin
            mon_r = rdy_q.pop_front();
            total++;
            if (mon_r.a !== mon_r.e) begin
                bad++;
                $display("FAIL wr_ready t=%0t got=%b exp=%b", $time, mon_r.a, mon_r.e);
            end
        end
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            total++;
            if (clk_o !== mon_x.c) begin
                bad++;
                $display("FAIL clk_o t=%0t got=%b exp=%b", $time, clk_o, mon_x.c);
            end
            total++;
            if (stb_o !== mon_x.s) begin
                bad++;
                $display("FAIL stb_o t=%0t got=%b exp=%b", $time, stb_o, mon_x.s);
            end
            total++;
            if (err_o !== mon_x.e) begin
                bad++;
                $display("FAIL err_o t=%0t got=%b exp=%b", $time, err_o, mon_x.e);
            end
        end
    end

    task automatic check_ready(input logic e);
        rdy_t r;
        #1;
        r.e = e;
        r.a = wr_ready;
        rdy_q.push_back(r);
    endtask

    task automatic wr(input logic v, input logic [SW-1:0] sel, input logic [W-1:0] div);
        wr_valid = v;
        wr_sel   = sel;
        wr_div   = div;
    endtask

    // Expected outputs after the coming rising edge, then advance one cycle
    task automatic step(input logic [N-1:0] c, input logic [N-1:0] s, input logic e);
        exp_t x;
        x.c = c;
        x.s = s;
        x.e = e;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset overrides enable, sync and a write; ready reads 1
        reset_n = 1'b0; en_i = 5'h1F; sync_i = 1'b1; wr(1'b1, 3'd1, 8'd1);
        check_ready(1'b1);
        step(5'h00, 5'h00, 1'b0);
        sync_i = 1'b0; en_i = 5'h00; wr(1'b0, 3'd0, 8'd0);
        step(5'h00, 5'h00, 1'b0);

        // Default divisor 2 on channel 0, then stop from phase 0
        reset_n = 1'b1; en_i = 5'h01;
        step(5'h01, 5'h01, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h01, 5'h01, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        en_i = 5'h00;
        step(5'h01, 5'h01, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);

        // Channel 1 at M=5, rewrite to 3 at p=1, second write stalls
        wr(1'b1, 3'd1, 8'd5);
        check_ready(1'b1);
        step(5'h00, 5'h00, 1'b0);
        wr(1'b0, 3'd1, 8'd0); en_i = 5'h02;
        step(5'h02, 5'h02, 1'b0);
        wr(1'b1, 3'd1, 8'd3);
        check_ready(1'b1);
        step(5'h02, 5'h00, 1'b0);
        wr(1'b1, 3'd1, 8'd7);
        check_ready(1'b0);
        step(5'h02, 5'h00, 1'b0);
        check_ready(1'b0);
        step(5'h00, 5'h00, 1'b0);
        check_ready(1'b0);
        step(5'h00, 5'h00, 1'b0);
        wr(1'b0, 3'd1, 8'd0);
        check_ready(1'b1);
        step(5'h02, 5'h02, 1'b0);
        step(5'h02, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h02, 5'h02, 1'b0);
        step(5'h02, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        en_i = 5'h00;
        step(5'h02, 5'h02, 1'b0);
        step(5'h02, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);

        // Channel 2 at M=6: drop enable at p=1, the period completes
        wr(1'b1, 3'd2, 8'd6);
        step(5'h00, 5'h00, 1'b0);
        wr(1'b0, 3'd0, 8'd0); en_i = 5'h04;
        step(5'h04, 5'h04, 1'b0);
        en_i = 5'h00;
        step(5'h04, 5'h00, 1'b0);
        step(5'h04, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        // Drop at p=1, re-assert at p=4: periods continue unbroken
        en_i = 5'h04;
        step(5'h04, 5'h04, 1'b0);
        en_i = 5'h00;
        step(5'h04, 5'h00, 1'b0);
        step(5'h04, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        en_i = 5'h04;
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h04, 5'h04, 1'b0);
        step(5'h04, 5'h00, 1'b0);
        step(5'h04, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        en_i = 5'h00;
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);

        // Channels 0..3 at M=2,3,4,7 with sync pulses
        wr(1'b1, 3'd2, 8'd4);
        step(5'h00, 5'h00, 1'b0);
        wr(1'b1, 3'd3, 8'd7);
        step(5'h00, 5'h00, 1'b0);
        wr(1'b0, 3'd0, 8'd0); en_i = 5'h0F;
        step(5'h0F, 5'h0F, 1'b0);
        step(5'h0E, 5'h00, 1'b0);
        step(5'h09, 5'h01, 1'b0);
        sync_i = 1'b1;
        step(5'h0F, 5'h0F, 1'b0);
        sync_i = 1'b0; wr(1'b1, 3'd2, 8'd2);
        check_ready(1'b1);
        step(5'h0E, 5'h00, 1'b0);
        wr(1'b0, 3'd2, 8'd0);
        check_ready(1'b0);
        step(5'h09, 5'h01, 1'b0);
        sync_i = 1'b1;
        step(5'h0F, 5'h0F, 1'b0);
        sync_i = 1'b0;
        check_ready(1'b1);
        step(5'h0A, 5'h00, 1'b0);
        // Sync together with enable drop: realign, then wind down
        sync_i = 1'b1; en_i = 5'h00;
        step(5'h0F, 5'h0F, 1'b0);
        sync_i = 1'b0;
        step(5'h0A, 5'h00, 1'b0);
        step(5'h08, 5'h00, 1'b0);
        step(5'h08, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);

        // Rejected writes: divisor 1 and out-of-range channel
        wr(1'b1, 3'd0, 8'd1);
        check_ready(1'b1);
        step(5'h00, 5'h00, 1'b1);
        wr(1'b1, 3'd5, 8'd4);
        check_ready(1'b1);
        step(5'h00, 5'h00, 1'b1);
        wr(1'b0, 3'd0, 8'd0);
        step(5'h00, 5'h00, 1'b0);
        en_i = 5'h01;
        step(5'h01, 5'h01, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h01, 5'h01, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        en_i = 5'h00;
        step(5'h01, 5'h01, 1'b0);
        step(5'h00, 5'h00, 1'b0);

        // Reset mid-period with a pending write
        en_i = 5'h02;
        step(5'h02, 5'h02, 1'b0);
        wr(1'b1, 3'd1, 8'd4);
        check_ready(1'b1);
        step(5'h02, 5'h00, 1'b0);
        reset_n = 1'b0; wr(1'b1, 3'd1, 8'd1);
        check_ready(1'b1);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        reset_n = 1'b1; wr(1'b0, 3'd1, 8'd0);
        check_ready(1'b1);
        step(5'h02, 5'h02, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h02, 5'h02, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        en_i = 5'h00;
        step(5'h02, 5'h02, 1'b0);
        step(5'h00, 5'h00, 1'b0);
        step(5'h00, 5'h00, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
